// File: rtl/button_pkg.sv
// Shared types and default timing constants for the button press counter.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_e;

  localparam int unsigned DEBOUNCE_DEFAULT = 120000;
  localparam int unsigned LONG_DEFAULT     = 12000000;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes the raw active-low button, debounces it and reports the
// debounced level plus a one-cycle strobe per accepted press.
module btn_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse,
  output logic accept_c
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  // Transition fires on the edge where the counter reaches DEBOUNCE_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic          sync1;
  logic          s;
  btn_state_e    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          pressed_d;

  // Two-flop synchronizer, stored active-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= ~btn_n;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RELEASED;
      cnt         <= '0;
      pressed     <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      pressed     <= pressed_d;
      press_pulse <= accept_c;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pressed_d = pressed;
    accept_c  = 1'b0;
    case (state)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state_d   = HELD;
            pressed_d = 1'b1;
            accept_c  = 1'b1;
          end
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (s) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state_d   = RELEASED;
            pressed_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = RELEASED;
      end
    endcase
  end

endmodule

// File: rtl/button_press_counter.sv
// Counts debounced button presses on a 4-bit led bus. Define LONG_PRESS_EN
// to add long-press detection, which clears led and strobes long_pulse.
module button_press_counter
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned LONG_CYCLES     = LONG_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  output logic [3:0] led,
  output logic       pressed,
  output logic       press_pulse,
  output logic       long_pulse
);

  logic accept_c;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .pressed    (pressed),
    .press_pulse(press_pulse),
    .accept_c   (accept_c)
  );

`ifdef LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_CYCLES);

  logic [HW-1:0] hold_cnt;
  logic          long_hit_c;

  // A long press landing on the acceptance edge is a configuration error.
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_cfg_err
    $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  assign long_hit_c = pressed && (hold_cnt == HW'(LONG_CYCLES - 2));

  // Hold counter runs while pressed (HELD/RELEASE_CHK) and saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (!pressed) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HW'(LONG_CYCLES - 1)) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led        <= 4'd0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= long_hit_c;
      if (long_hit_c) begin
        led <= 4'd0;
      end else if (accept_c) begin
        led <= led + 4'd1;
      end
    end
  end
`else
  assign long_pulse = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= 4'd0;
    end else if (accept_c) begin
      led <= led + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_button_press_counter.sv
// Directed bench for button_press_counter with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_button_press_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_n;
  logic [3:0] led;
  logic       pressed;
  logic       press_pulse;
  logic       long_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int n_press  = 0;
  int n_long   = 0;

  button_press_counter #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .led        (led),
    .pressed    (pressed),
    .press_pulse(press_pulse),
    .long_pulse (long_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (press_pulse === 1'b1) n_press++;
    if (long_pulse === 1'b1) n_long++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int n_low, input int n_high);
    btn_n = 1'b0;
    tick(n_low);
    btn_n = 1'b1;
    tick(n_high);
  endtask

  int p0;
  int l0;
  int still;

  initial begin
    rst   = 1'b1;
    btn_n = 1'b1;
    tick(3);
    check("reset_led", int'(led), 0);
    check("reset_pressed", int'(pressed), 0);
    check("reset_press_pulse", int'(press_pulse), 0);
    check("reset_long_pulse", int'(long_pulse), 0);
    rst = 1'b0;
    tick(4);
    check("rst_release_no_strobe", n_press, 0);

    // Clean press: pressed and strobe on the 6th clock after the edge
    p0    = n_press;
    btn_n = 1'b0;
    tick(5);
    check("clean_pressed_early", int'(pressed), 0);
    tick(1);
    check("clean_pressed", int'(pressed), 1);
    check("clean_pulse", int'(press_pulse), 1);
    check("clean_led", int'(led), 1);
    tick(1);
    check("clean_pulse_one_cycle", int'(press_pulse), 0);
    tick(3);
    check("clean_pulse_count", n_press - p0, 1);
    btn_n = 1'b1;
    tick(5);
    check("release_pressed_early", int'(pressed), 1);
    tick(1);
    check("release_pressed", int'(pressed), 0);
    tick(4);

    // Bounce: 3 low, 2 high, then held low
    p0 = n_press;
    btn_n = 1'b0;
    tick(3);
    btn_n = 1'b1;
    tick(2);
    check("bounce_not_pressed", int'(pressed), 0);
    check("bounce_led_held", int'(led), 1);
    btn_n = 1'b0;
    tick(10);
    check("bounce_pulse_count", n_press - p0, 1);
    check("bounce_led", int'(led), 2);

    // Release glitch while held
    p0 = n_press;
    btn_n = 1'b1;
    tick(2);
    btn_n = 1'b0;
    still = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (pressed !== 1'b1) still = 0;
    end
    check("glitch_pressed_stays", still, 1);
    check("glitch_no_pulse", n_press - p0, 0);
    check("glitch_led", int'(led), 2);
    btn_n = 1'b1;
    tick(10);

    // Wrap after 16 presses from reset
    rst = 1'b1;
    tick(2);
    check("wrap_reset_led", int'(led), 0);
    rst = 1'b0;
    tick(2);
    p0 = n_press;
    for (int i = 0; i < 15; i++) press(8, 8);
    check("wrap_led_15", int'(led), 15);
    press(8, 8);
    check("wrap_led_0", int'(led), 0);
    check("wrap_pulse_count", n_press - p0, 16);

    // Reset mid-press, button kept low across reset
    press(8, 8);
    check("pre_reset_led", int'(led), 1);
    p0    = n_press;
    btn_n = 1'b0;
    tick(5);
    rst = 1'b1;
    #1;
    check("midrst_led", int'(led), 0);
    check("midrst_pressed", int'(pressed), 0);
    tick(2);
    check("midrst_no_pulse", n_press - p0, 0);
    rst = 1'b0;
    tick(5);
    check("midrst_pulse_early", int'(press_pulse), 0);
    tick(1);
    check("midrst_pulse", int'(press_pulse), 1);
    check("midrst_led_after", int'(led), 1);
    btn_n = 1'b1;
    tick(10);

    // Long press from led=5
    for (int i = 0; i < 3; i++) press(8, 8);
    check("long_pre_led", int'(led), 4);
    l0    = n_long;
    btn_n = 1'b0;
    tick(30);
`ifdef LONG_PRESS_EN
    check("long_pulse_count", n_long - l0, 1);
    check("long_led_cleared", int'(led), 0);
    btn_n = 1'b1;
    tick(12);
    check("long_release_led", int'(led), 0);
    check("long_pulse_once", n_long - l0, 1);
`else
    check("nolong_pulse_count", n_long, 0);
    check("nolong_led", int'(led), 5);
    btn_n = 1'b1;
    tick(12);
    check("nolong_release_led", int'(led), 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_press_counter.md
BUTTON_PRESS_COUNTER -- requirements
Module: button_press_counter

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 120000, the number of clocks the input must hold stable (10 ms at 12 MHz).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 12000000, the number of debounced-held clocks that make a long press (1 s at 12 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port btn_n, input, 1 bit: raw asynchronous button line, active-low (0 means pressed).
REQ-006 The block SHALL have port led, output, 4 bits: press count.
REQ-007 The block SHALL have port pressed, output, 1 bit: debounced button level, 1 means pressed.
REQ-008 The block SHALL have port press_pulse, output, 1 bit: one-cycle strobe on each accepted press.
REQ-009 The block SHALL have port long_pulse, output, 1 bit: one-cycle strobe on long-press detection; it is tied 0 when LONG_PRESS_EN is undefined.

Function
REQ-010 btn_n SHALL pass through a 2-flop synchronizer; the synchronized active-high level is s.
REQ-011 The FSM SHALL have states RELEASED, PRESS_CHK, HELD and RELEASE_CHK.
REQ-012 In RELEASED, s=1 SHALL move the FSM to PRESS_CHK and clear the debounce counter.
REQ-013 In PRESS_CHK, the debounce counter SHALL increment each clock while s=1; s=0 SHALL return the FSM to RELEASED with no output change.
REQ-014 When the debounce counter reaches DEBOUNCE_CYCLES-1 with s=1, the FSM SHALL enter HELD; on that same edge pressed←1, press_pulse←1 for one cycle, and led←led+1.
REQ-015 Total latency from a btn_n falling edge to pressed=1 SHALL be DEBOUNCE_CYCLES+2 clocks for a clean edge.
REQ-016 In HELD, s=0 SHALL move the FSM to RELEASE_CHK and clear the debounce counter.
REQ-017 In RELEASE_CHK, DEBOUNCE_CYCLES consecutive clocks of s=0 SHALL return the FSM to RELEASED with pressed←0; any s=1 SHALL return the FSM to HELD with no new press_pulse and no led change.
REQ-018 led SHALL wrap from 15 to 0 without saturation.
REQ-019 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no press_pulse and no change to pressed or led.
REQ-020 The debounce counter SHALL be $clog2(DEBOUNCE_CYCLES) bits wide and SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-021 press_pulse and long_pulse SHALL each be 0 in every cycle other than the defined strobe cycle.

Reset
REQ-022 While rst=1: synchronizer flops SHALL be 0 (released), the FSM SHALL be RELEASED, both counters SHALL be 0, led SHALL be 0, and pressed, press_pulse and long_pulse SHALL be 0.
REQ-023 Reset mid-press SHALL abort the press; after release of reset with the button still held, a new full debounce SHALL be required before press_pulse.
REQ-024 Deassertion of rst SHALL produce no spurious strobe.

Configuration
REQ-025 The macro LONG_PRESS_EN SHALL gate the long-press feature.
REQ-026 With LONG_PRESS_EN defined, a hold counter SHALL count clocks spent in HELD and RELEASE_CHK. When it reaches LONG_CYCLES-1: led←0, long_pulse←1 for one cycle, and the counter saturates. The counter SHALL clear on entry to RELEASED. One long_pulse SHALL be issued per press.
REQ-027 When long press and press acceptance fall on the same edge (LONG_CYCLES<=DEBOUNCE_CYCLES, illegal), the design SHALL treat the combination as a configuration error, flagged by an elaboration-time assertion.
REQ-028 Without LONG_PRESS_EN, there SHALL be no hold counter logic and long_pulse SHALL be constant 0.

Structure
REQ-029 The shared package button_pkg SHALL hold the FSM state enum and the default constants DEBOUNCE_DEFAULT=120000 and LONG_DEFAULT=12000000.
REQ-030 The synchronizer, debounce counter and FSM SHALL form sub-module btn_debounce, which outputs pressed and press_pulse. The top level SHALL contain the led counter and the long-press logic.

Verification (sim parameters DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-031 Clean press: btn_n falls and is held 10 clocks → pressed=1 and press_pulse at clock 6 after the edge, led 0→1.
REQ-032 Bounce: btn_n low 3 clocks, high 2, low held → exactly one press_pulse, led=1.
REQ-033 Wrap: 16 clean presses → led returns to 0, 16 press_pulses.
REQ-034 Release glitch: while HELD, btn_n high 2 clocks then low → no extra press_pulse, pressed stays 1.
REQ-035 Reset mid-press: rst asserted at clock 3 of PRESS_CHK → led=0 and no pulse; after rst falls with the button still low, press_pulse at clock 6.
REQ-036 Long press (LONG_PRESS_EN): led=5, button held 30 clocks → long_pulse once, led=0, and no led change on release.
